fetch_queue: RTL
================

# fetch_queue

Circular instruction queue between the fetch stage and the decode/issue stage of the out-of-order core. Fetch pushes one predicted instruction record per cycle: instruction bits, PC, alternate PC and the gshare prediction bit. Decode pops records in program order under a valid/ready handshake. The whole queue is discarded in one cycle when commit signals a misprediction.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, ≥2
- ADDR_WIDTH, 64: PC width

Ports:
- clk_in  input  1  clock; all state updates on the rising edge
- rst_in  input  1  reset, asynchronous, active-high
- flush_in  input  1  mispredict flush from commit; empties the queue
- enq_valid_in  input  1  fetch presents a record
- enq_ready_out  output  1  queue can accept a record this cycle
- enq_insn_in  input  32  instruction bits
- enq_pc_in  input  ADDR_WIDTH  PC of the instruction
- enq_other_pc_in  input  ADDR_WIDTH  non-predicted successor PC
- enq_pred_in  input  1  gshare taken prediction
- deq_valid_out  output  1  head record is valid
- deq_ready_in  input  1  decode consumes the head this cycle
- deq_insn_out  output  32  head instruction bits
- deq_pc_out  output  ADDR_WIDTH  head PC
- deq_other_pc_out  output  ADDR_WIDTH  head alternate PC
- deq_pred_out  output  1  head prediction bit
- count_out  output  $clog2(DEPTH)+1  current occupancy

## Operation
- State: DEPTH-entry storage array, head pointer, tail pointer (each $clog2(DEPTH) bits, wrapping modulo DEPTH), and a count register.
- No FSM. Occupancy is the only control state: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
- Enqueue fires when enq_valid_in && enq_ready_out. It writes the record at tail, then tail+1.
- Dequeue fires when deq_valid_out && deq_ready_in. It sets head to head+1.
- enq_ready_out = (count != DEPTH). It does not depend on deq_ready_in, so a full queue with a same-cycle dequeue still refuses the enqueue.
- deq_valid_out = (count != 0), except as noted under Configuration.
- deq_* data outputs are driven combinationally from the storage entry at head. They are don't-care while deq_valid_out=0; the bench must not check them then.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- flush_in has the highest priority:
  - head, tail and count are set to 0 on the next edge.
  - Any enqueue or dequeue presented in the flush cycle is discarded, and count does not change because of it.
  - Storage contents are not cleared.
- Enqueue with enq_ready_out=0 and dequeue with deq_valid_out=0 are ignored. No error is flagged and no state changes.

## Timing
- Reset values (asynchronous assertion, held until deassertion):
  - head=0, tail=0, count=0
  - deq_valid_out=0, enq_ready_out=1, count_out=0
  - deq_insn_out, deq_pc_out, deq_other_pc_out and deq_pred_out are 0, because storage resets to 0.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency without the bypass: a record enqueued at edge N is visible on deq_* after edge N, so decode can consume it at edge N+1. Minimum latency is one cycle.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- Flush at edge N: deq_valid_out=0 and count_out=0 after edge N. A new enqueue is accepted at edge N+1.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count=0 and enq_valid_in=1 (and flush_in=0), deq_valid_out=1 and deq_* are driven directly from the enq_* inputs.
  - If deq_ready_in=1 in that cycle, the record passes through with zero latency. No storage is written, and neither pointer nor count changes.
  - If deq_ready_in=0, the record is enqueued normally.
- FETCH_QUEUE_BYPASS_EN undefined:
  - No combinational path exists from enq_* to deq_*.
  - Minimum latency is one cycle, as described under Timing.

## Test plan
- Reset: assert rst_in between edges → immediately deq_valid_out=0, enq_ready_out=1, count_out=0. Release it → state stays the same.
- Fill (DEPTH=4, deq_ready_in=0): enqueue PCs 0x1000, 0x1004, 0x1008, 0x100C → count_out=4 and enq_ready_out=0. A fifth record with PC 0x1010 is dropped, and deq_pc_out stays 0x1000.
- Drain and wrap: from full, dequeue 2 and enqueue 0x1010 and 0x1014, then dequeue everything → PCs come out in order 0x1008, 0x100C, 0x1010, 0x1014, and deq_insn_out, deq_other_pc_out and deq_pred_out match each PC's enqueued values.
- Simultaneous: with count=2, enq and deq fire together for 10 cycles → count_out stays 2 and output order is preserved.
- Flush: with count=3, assert flush_in together with enq_valid_in=1 → after the edge count_out=0 and deq_valid_out=0. Enqueue 0x2000 next cycle → deq_pc_out=0x2000 one cycle later.
- Bypass (macro defined): empty queue, enq_valid_in=1 with PC 0x3000, deq_ready_in=1 → deq_valid_out=1 and deq_pc_out=0x3000 in the same cycle, with count_out still 0 after the edge. With the macro undefined → deq_valid_out=0 in that cycle and count_out=1 after the edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: 1-cycle enq->deq latency (0 with FETCH_QUEUE_BYPASS_EN), one push and one pop per cycle.
// Backpressure: enq_ready_out drops only when full (independent of deq_ready_in); flush_in empties the queue in one edge.
module fetch_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   flush_in,
  input  logic                   enq_valid_in,
  output logic                   enq_ready_out,
  input  logic [31:0]            enq_insn_in,
  input  logic [ADDR_WIDTH-1:0]  enq_pc_in,
  input  logic [ADDR_WIDTH-1:0]  enq_other_pc_in,
  input  logic                   enq_pred_in,
  output logic                   deq_valid_out,
  input  logic                   deq_ready_in,
  output logic [31:0]            deq_insn_out,
  output logic [ADDR_WIDTH-1:0]  deq_pc_out,
  output logic [ADDR_WIDTH-1:0]  deq_other_pc_out,
  output logic                   deq_pred_out,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0]           insn;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] other_pc;
    logic                  pred;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  rec_t enq_rec;
  rec_t deq_rec;
  logic byp_vld;
  logic byp_take;
  logic deq_vld;
  logic enq_rdy;
  logic wr_en;
  logic rd_en;

  always_comb begin
    enq_rec.insn     = enq_insn_in;
    enq_rec.pc       = enq_pc_in;
    enq_rec.other_pc = enq_other_pc_in;
    enq_rec.pred     = enq_pred_in;
  end

  // Handshake decode. A bypassed-and-consumed record never touches storage.
  always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_vld = (count_q == '0) && enq_valid_in && !flush_in;
    deq_rec = byp_vld ? enq_rec : mem_q[head_q];
`else
    byp_vld = 1'b0;
    deq_rec = mem_q[head_q];
`endif
    deq_vld  = (count_q != '0) || byp_vld;
    enq_rdy  = (count_q != CNT_FULL);
    byp_take = byp_vld && deq_ready_in;
    wr_en    = enq_valid_in && enq_rdy && !byp_take && !flush_in;
    rd_en    = deq_vld && deq_ready_in && !byp_take && !flush_in;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_en) begin
      mem_d[tail_q] = enq_rec;
    end
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PTR_ONE;
      if (rd_en) head_d = head_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is reset so the head outputs read as zero straight out of reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign enq_ready_out    = enq_rdy;
  assign deq_valid_out    = deq_vld;
  assign deq_insn_out     = deq_rec.insn;
  assign deq_pc_out       = deq_rec.pc;
  assign deq_other_pc_out = deq_rec.other_pc;
  assign deq_pred_out     = deq_rec.pred;
  assign count_out        = count_q;

endmodule
